iomem_uart_tx: RTL and testbench
================================

Name: iomem_uart_tx

Overview:
- Memory-mapped UART transmitter; responder on the SoC iomem bus, on which the SoC is the initiator.
- The CPU writes bytes into an internal TX FIFO.
- A baud-rate FSM serialises the bytes as 8N1 onto a single output pin.
- Sits beside the SoC at top level, decoding its own address window and leaving other addresses to other responders.

Parameters:
- BASE_ADDR, 32'h0200_0000, base of the 16-byte register window; bits [3:0] are ignored.
- DEFAULT_DIV, 16'd104, reset value of the baud divisor in clk cycles per bit (12 MHz / 115200).
- FIFO_AW, 3, log2 of TX FIFO depth (default depth 8).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- iomem_valid  input  1  initiator request valid; held until ready
- iomem_ready  output  1  one-cycle acknowledge
- iomem_addr  input  32  byte address
- iomem_wdata  input  32  write data
- iomem_wstrb  input  4  byte write strobes; all zero means read
- iomem_rdata  output  32  read data; valid only while iomem_ready=1
- uart_tx  output  1  serial output; idles high

Behaviour:
- Reset values: iomem_ready=0, iomem_rdata=0, uart_tx=1, FIFO empty, DIV=DEFAULT_DIV, FSM in IDLE. Reset is asynchronous and takes effect mid-frame or mid-transaction.
- Address decode: selected when iomem_valid=1 and iomem_addr[31:4]==BASE_ADDR[31:4]. When not selected, iomem_ready and iomem_rdata stay 0.
- Register map (offset = addr[3:2]):
  - 0x0 DATA (W): push wdata[7:0] when wstrb[0]=1. Reads return 0.
  - 0x4 DIV (R/W): bits [15:0]. wstrb[0] writes [7:0]; wstrb[1] writes [15:8]. A resulting value <2 is stored as 2.
  - 0x8 STATUS (R): bit0 fifo_full, bit1 fifo_empty, bit2 busy (FSM not IDLE), bits[8+FIFO_AW:8] fifo level (0..depth). All other bits 0.
  - 0xC: reads 0; writes ignored; acknowledged normally.
- Handshake:
  - A selected request is sampled at edge N. iomem_ready=1 for exactly one cycle after edge N, i.e. latency 1 cycle.
  - Register update and FIFO push happen at that same edge.
  - The cycle after ready is a dead cycle: valid is ignored, so a lingering valid is never double-accepted.
- Backpressure: a DATA write while fifo_full=1 is stalled (ready held 0) until the FSM pops an entry. The write is then accepted on the next cycle; no byte is dropped.
- DATA write with wstrb[0]=0 but other strobes set: acknowledged, no push.
- FIFO:
  - Circular buffer with read/write pointers FIFO_AW+1 bits wide; wrap-around via the MSB.
  - Full = pointers equal except MSB; empty = pointers equal.
  - Push and pop in the same cycle are allowed when not full: level is unchanged.
- TX FSM states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1. If the FIFO is not empty: pop into the shift register, latch DIV into the bit-period register, go to START.
  - START: uart_tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for DIV cycles, then shift right. After bit 7, go to STOP.
  - STOP: uart_tx=1 for DIV cycles. Then go to START directly if the FIFO is not empty (same pop/latch as IDLE); otherwise go to IDLE.
- Bit timing: one down-counter loaded with latched DIV-1; a bit ends when it reaches 0. A frame lasts exactly 10*DIV cycles.
- A DIV write mid-frame does not affect the current frame; it applies from the next popped byte.
- uart_tx is driven from a register, so it is glitch-free.

Test Plan:
- Reset, then read STATUS at 0x0200_0008 -> rdata=0x0000_0002; uart_tx=1; ready asserted one cycle after valid.
- Write DIV=4, write DATA=0xA5 -> uart_tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high. Frame = 40 cycles; busy=0 afterwards.
- Write DIV=2, push 9 bytes 0x00..0x08 back-to-back -> 9th write stalled until the first pop. All 9 bytes transmitted in order with no idle gap between frames. STATUS level peaks at 8 and full=1 while stalled.
- Write DIV=0 -> DIV reads back 0x0000_0002. Write DIV=8 during a frame -> current frame keeps the old timing; next frame uses 8-cycle bits.
- Access 0x0300_0000 with valid held 10 cycles -> iomem_ready stays 0, rdata 0.
- Assert rst mid-DATA of byte 0x3C with 3 bytes queued -> uart_tx=1 immediately. After release: STATUS=0x2, DIV=104, nothing transmitted.

Source files
------------

// File: rtl/iomem_uart_tx_if.sv
// iomem bus bundle: the SoC drives requests (master), a memory-mapped
// peripheral answers with a one-cycle ready pulse and read data (slave).
interface iomem_uart_tx_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/iomem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a small FIFO
// on the iomem bus and a divisor-timed FSM shifts them out on uart_tx.
module iomem_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter logic [15:0] DEFAULT_DIV = 16'd104,
  parameter int          FIFO_AW     = 3
) (
  input  logic           clk,
  input  logic           rst,
  iomem_uart_tx_if.slave bus,
  output logic           uart_tx
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr, level;
  logic             full, empty;
  logic             sel, wr, data_push, accept, push, pop, bit_end, busy;
  logic [1:0]       reg_off;
  logic             ready_q, dead_q;
  logic [31:0]      rdata_q, status;
  logic [15:0]      div, div_next, cnt, period;
  logic [1:0]       state;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic             unused_bits;

  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:16]};

  assign sel       = bus.valid && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr        = |bus.wstrb;
  assign reg_off   = bus.addr[3:2];
  assign data_push = wr && (reg_off == 2'd0) && bus.wstrb[0];
  // A push into a full FIFO simply waits; ready and dead cycles block re-acceptance.
  assign accept    = sel && !ready_q && !dead_q && !(data_push && full);
  assign push      = accept && data_push;

  assign level = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);

  assign bit_end = (cnt == 16'd0);
  assign busy    = (state != S_IDLE);
  assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  assign div_next = {bus.wstrb[1] ? bus.wdata[15:8] : div[15:8],
                     bus.wstrb[0] ? bus.wdata[7:0]  : div[7:0]};

  always_comb begin
    status                  = '0;
    status[0]               = full;
    status[1]               = empty;
    status[2]               = busy;
    status[8 +: FIFO_AW+1]  = level;
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      dead_q  <= 1'b0;
      rdata_q <= '0;
      div     <= DEFAULT_DIV;
    end else begin
      ready_q <= accept;
      dead_q  <= ready_q;
      rdata_q <= '0;
      if (accept && !wr) begin
        case (reg_off)
          2'd1:    rdata_q <= {16'h0000, div};
          2'd2:    rdata_q <= status;
          default: rdata_q <= '0;
        endcase
      end
      // A divisor below 2 cannot form a bit period, so it is clamped.
      if (accept && wr && (reg_off == 2'd1))
        div <= (div_next < 16'd2) ? 16'd2 : div_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[FIFO_AW-1:0]] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // The divisor is captured at pop time so mid-frame DIV writes only affect later bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      period  <= DEFAULT_DIV;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift   <= mem[rptr[FIFO_AW-1:0]];
            period  <= div;
            cnt     <= div - 16'd1;
            state   <= S_START;
            uart_tx <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            cnt     <= period - 16'd1;
            uart_tx <= shift[0];
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= period - 16'd1;
            if (bit_idx == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            if (pop) begin
              shift   <= mem[rptr[FIFO_AW-1:0]];
              period  <= div;
              cnt     <= div - 16'd1;
              state   <= S_START;
              uart_tx <= 1'b0;
            end else begin
              state   <= S_IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iomem_uart_tx.sv
// Self-checking bench for iomem_uart_tx: a frame-timing model predicts the
// serial line and bus responses each cycle, plus directed literal checks.
module tb_iomem_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_tx;
  logic check_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  iomem_uart_tx_if bus();

  iomem_uart_tx #(
    .BASE_ADDR  (32'h0200_0000),
    .DEFAULT_DIV(16'd104),
    .FIFO_AW    (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Model state: FIFO contents as a queue, the frame in flight as start/end times.
  logic [7:0]  mq[$];
  logic        m_ready = 1'b0;
  logic        m_dead  = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [15:0] m_div   = 16'd104;
  logic        exp_tx  = 1'b1;
  logic        f_valid = 1'b0;
  logic [7:0]  f_byte  = '0;
  int          f_start = 0;
  int          f_end   = 0;
  int          f_div   = 1;
  int          cyc     = 0;

  int          low_runs[$];
  int          run_len = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b0;
    m_dead  = 1'b0;
    m_rdata = '0;
    m_div   = 16'd104;
    exp_tx  = 1'b1;
    f_valid = 1'b0;
    f_end   = 0;
  endtask

  task automatic model_step();
    logic        sel_m, wr_m, acc_m, busy_m, full_m;
    logic [15:0] nd;
    int          bitno;
    cyc++;
    sel_m  = bus.valid && (bus.addr[31:4] == 28'h020_0000);
    wr_m   = (bus.wstrb != 4'b0000);
    full_m = (mq.size() == 8);
    busy_m = f_valid && (f_end >= cyc);
    acc_m  = sel_m && !m_ready && !m_dead &&
             !(wr_m && bus.addr[3:2] == 2'd0 && bus.wstrb[0] && full_m);
    m_rdata = '0;
    if (acc_m && !wr_m) begin
      if (bus.addr[3:2] == 2'd1) m_rdata = {16'h0000, m_div};
      if (bus.addr[3:2] == 2'd2)
        m_rdata = {20'h0, 4'(mq.size()), 5'b0, busy_m, (mq.size() == 0), full_m};
    end
    if ((!f_valid || f_end <= cyc) && mq.size() != 0) begin
      f_byte  = mq.pop_front();
      f_div   = int'(m_div);
      f_start = cyc;
      f_end   = cyc + 10 * f_div;
      f_valid = 1'b1;
    end
    m_dead  = m_ready;
    m_ready = acc_m;
    if (acc_m && wr_m) begin
      if (bus.addr[3:2] == 2'd0 && bus.wstrb[0]) mq.push_back(bus.wdata[7:0]);
      if (bus.addr[3:2] == 2'd1) begin
        nd = {bus.wstrb[1] ? bus.wdata[15:8] : m_div[15:8],
              bus.wstrb[0] ? bus.wdata[7:0]  : m_div[7:0]};
        m_div = (nd < 16'd2) ? 16'd2 : nd;
      end
    end
    exp_tx = 1'b1;
    if (f_valid && cyc >= f_start && cyc < f_end) begin
      bitno = (cyc - f_start) / f_div;
      if (bitno == 0)      exp_tx = 1'b0;
      else if (bitno < 9)  exp_tx = f_byte[bitno-1];
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      checkOutput("uart_tx", {31'b0, uart_tx}, {31'b0, exp_tx});
      checkOutput("iomem_ready", {31'b0, bus.ready}, {31'b0, m_ready});
      checkOutput("iomem_rdata", bus.rdata, m_rdata);
      if (rst) run_len = 0;
      else if (uart_tx === 1'b0) run_len++;
      else if (run_len > 0) begin
        low_runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, output logic [31:0] rdata,
                               output int lat);
    bus.valid = 1'b1;
    bus.addr  = addr;
    bus.wdata = wdata;
    bus.wstrb = wstrb;
    lat   = 0;
    rdata = '0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.ready === 1'b1) begin
        rdata = bus.rdata;
        break;
      end
      if (lat >= 3000) begin
        checks++;
        errors++;
        $display("[TB] FAIL handshake_timeout addr=0x%08h waited=%0d required<3000", addr, lat);
        break;
      end
    end
    bus.valid = 1'b0;
    bus.wstrb = 4'b0000;
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] rd;
    int          lat;
    applyStimulus(addr, data, strb, rd, lat);
  endtask

  task automatic rd_reg(input logic [31:0] addr, output logic [31:0] data);
    int lat;
    applyStimulus(addr, 32'h0, 4'b0000, data, lat);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  pat;
    int          lat;

    bus.valid = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wstrb = '0;
    #2 rst = 1'b1;
    #1 check_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    applyStimulus(32'h0200_0008, 32'h0, 4'b0000, rd, lat);
    checkOutput("status_after_reset", rd, 32'h0000_0002);
    checkOutput("ready_latency", lat, 1);
    checkOutput("uart_tx_idle", {31'b0, uart_tx}, 32'h1);
    rd_reg(32'h0200_0004, rd);
    checkOutput("div_after_reset", rd, 32'd104);

    $display("[TB] single frame 0xA5 at DIV=4");
    wr_reg(32'h0200_0004, 32'd4, 4'b0011);
    wr_reg(32'h0200_0000, 32'hA5, 4'b0001);
    pat = 10'b1_10100101_0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      checkOutput("a5_bit", {31'b0, uart_tx}, {31'b0, pat[k/4]});
    end
    @(posedge clk);
    #1;
    rd_reg(32'h0200_0008, rd);
    checkOutput("status_after_a5", rd, 32'h0000_0002);

    $display("[TB] fill FIFO behind a long frame, then stall");
    wr_reg(32'h0200_0004, 32'd100, 4'b0011);
    wr_reg(32'h0200_0000, 32'hFF, 4'b0001);
    wr_reg(32'h0200_0004, 32'd2, 4'b0011);
    for (int b = 0; b < 8; b++) wr_reg(32'h0200_0000, 32'(b), 4'b0001);
    rd_reg(32'h0200_0008, rd);
    checkOutput("status_full", rd, 32'h0000_0805);
    applyStimulus(32'h0200_0000, 32'h08, 4'b0001, rd, lat);
    checkOutput("stall_long", {31'b0, (lat > 900)}, 32'h1);
    repeat (200) @(posedge clk);
    #1;
    rd_reg(32'h0200_0008, rd);
    checkOutput("status_drained", rd, 32'h0000_0002);

    $display("[TB] DIV clamp and mid-frame DIV change");
    wr_reg(32'h0200_0004, 32'd0, 4'b0011);
    rd_reg(32'h0200_0004, rd);
    checkOutput("div_clamped", rd, 32'h0000_0002);
    low_runs.delete();
    wr_reg(32'h0200_0000, 32'h81, 4'b0001);
    wr_reg(32'h0200_0004, 32'd8, 4'b0011);
    wr_reg(32'h0200_0000, 32'hC3, 4'b0001);
    repeat (110) @(posedge clk);
    #1;
    checkOutput("low_run_count", low_runs.size(), 4);
    if (low_runs.size() == 4) begin
      checkOutput("run0_start_div2", low_runs[0], 2);
      checkOutput("run1_bits_div2", low_runs[1], 12);
      checkOutput("run2_start_div8", low_runs[2], 8);
      checkOutput("run3_bits_div8", low_runs[3], 32);
    end

    $display("[TB] register map corners");
    wr_reg(32'h0200_000C, 32'hFFFF_FFFF, 4'b1111);
    rd_reg(32'h0200_000C, rd);
    checkOutput("reg_c_reads_zero", rd, 32'h0);
    rd_reg(32'h0200_0000, rd);
    checkOutput("data_reads_zero", rd, 32'h0);
    wr_reg(32'h0200_0004, 32'h0000_0100, 4'b0010);
    rd_reg(32'h0200_0004, rd);
    checkOutput("div_high_byte_only", rd, 32'h0000_0108);
    wr_reg(32'h0200_0000, 32'h0000_5500, 4'b0010);
    rd_reg(32'h0200_0008, rd);
    checkOutput("no_push_without_strb0", rd, 32'h0000_0002);

    $display("[TB] foreign address");
    bus.valid = 1'b1;
    bus.addr  = 32'h0300_0000;
    bus.wstrb = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("foreign_ready", {31'b0, bus.ready}, 32'h0);
      checkOutput("foreign_rdata", bus.rdata, 32'h0);
    end
    bus.valid = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset mid-frame");
    wr_reg(32'h0200_0004, 32'd4, 4'b0011);
    wr_reg(32'h0200_0000, 32'h3C, 4'b0001);
    wr_reg(32'h0200_0000, 32'h11, 4'b0001);
    wr_reg(32'h0200_0000, 32'h22, 4'b0001);
    wr_reg(32'h0200_0000, 32'h33, 4'b0001);
    checkOutput("tx_low_before_reset", {31'b0, uart_tx}, 32'h0);
    #2 rst = 1'b1;
    #1;
    checkOutput("tx_high_in_reset", {31'b0, uart_tx}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    low_runs.delete();
    rd_reg(32'h0200_0008, rd);
    checkOutput("status_after_midreset", rd, 32'h0000_0002);
    rd_reg(32'h0200_0004, rd);
    checkOutput("div_after_midreset", rd, 32'd104);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("nothing_sent_after_reset", low_runs.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
